// File: rtl/freq_bcd_pkg.sv
// rtl/freq_bcd_pkg.sv - shared state type, default sizes and digit-count helper for freq_bcd_conv
package freq_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    // ceil(w * log10(2)) using a fixed-point log10(2) of 0.30103
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - combinational conditional add-3 for one BCD digit
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // digits of 5 or more get 3 added so the following shift carries correctly
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/freq_bcd_conv.sv
// rtl/freq_bcd_conv.sv - sequential shift-add-3 binary to BCD converter (optional FREQ_BCD_AUTO_EN)
module freq_bcd_conv
    import freq_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    // too few digits would silently truncate the largest inputs
    if (DIGITS < min_digits(WIDTH)) begin : g_cfg_err
        $error("freq_bcd_conv: DIGITS too small for WIDTH");
    end

    state_t               state;
    state_t               state_nx;
    logic [WIDTH-1:0]     shift_q;
    logic [SW-1:0]        scratch;
    logic [SW-1:0]        adj;
    logic [SW+WIDTH-1:0]  shifted;
    logic [CW-1:0]        cnt;
    logic                 last_iter;
    logic                 go;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scratch[4*i +: 4]),
            .q (adj[4*i +: 4])
        );
    end

    assign shifted   = {adj, shift_q} << 1;
    assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef FREQ_BCD_AUTO_EN
    logic [WIDTH-1:0] last_bin;
    logic             first;

    assign go = start | first | (bin != last_bin);

    // remember what was last converted; first forces one conversion after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_bin <= '0;
            first    <= 1'b1;
        end else if (state == IDLE && go) begin
            last_bin <= bin;
            first    <= 1'b0;
        end
    end
`else
    assign go = start;
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic; requests outside IDLE are simply dropped
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = CONV;
            CONV:    if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == CONV);
    assign done = (state == DONE);

    // datapath: capture, iterate, and publish the result only when complete
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        shift_q <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                CONV: begin
                    shift_q <= shifted[WIDTH-1:0];
                    scratch <= shifted[SW+WIDTH-1:WIDTH];
                    cnt     <= cnt + CW'(1);
                    if (last_iter) begin
                        bcd <= shifted[SW+WIDTH-1:WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
